reg_status_table_mp: RTL
========================

Name: reg_status_table_mp

Overview:
Parametrised multi-port Register Status Table (RST) for the Tomasulo dispatch unit. Tracks, per architectural register, whether a result is pending and which reservation-station tag will produce it. Supports multiple dispatch writes and multiple CDB broadcasts per cycle, with same-cycle CDB forwarding on reads. Sits between the decode/rename stage, the register file write-enable logic and the CDB arbiter.

Parameters:
NUM_REGS, 32, architectural registers; power of 2; AW = $clog2(NUM_REGS)
TAG_W, 6, reservation-station tag width
NUM_RD, 4, read ports (2 per dispatched instruction)
NUM_DISP, 2, dispatch write ports; higher index is later in program order
NUM_CDB, 2, CDB broadcast ports
R0_HARDWIRED, 1, 1 = register 0 is never busy; writes to it are ignored

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
disp_we  input  NUM_DISP  per-port dispatch write enable
disp_addr  input  NUM_DISP*AW  destination register per port, packed
disp_tag  input  NUM_DISP*TAG_W  producing RS tag per port
cdb_valid  input  NUM_CDB  broadcast valid per CDB
cdb_tag  input  NUM_CDB*TAG_W  broadcast tag per CDB
rd_addr  input  NUM_RD*AW  source register per read port
rd_busy  output  NUM_RD  1 = operand pending
rd_tag  output  NUM_RD*TAG_W  pending tag; 0 when not busy
rf_write_en  output  NUM_REGS  one-hot-per-register RF write strobe
rf_write_sel  output  NUM_REGS*$clog2(NUM_CDB)  CDB index feeding each register's RF write
busy_count  output  AW+1  registered count of busy entries

Behaviour:
- Storage per entry: busy bit plus TAG_W tag. Tag 0 is a legal tag; validity comes only from the busy bit.
- Reset asserted (low) takes effect immediately: all busy=0, all tags=0, busy_count=0. Consequently rd_busy=0, rd_tag=0, rf_write_en=0 and rf_write_sel=0. Reset mid-cycle discards any in-flight dispatch or CDB event.
- CDB match: entry i matches CDB k when busy[i] && cdb_valid[k] && tag[i]==cdb_tag[k]. Combinationally: rf_write_en[i]=1 and rf_write_sel[i] = lowest matching k. Next edge: busy[i] clears unless overridden by a dispatch write.
- Dispatch write: on the edge, busy[disp_addr]=1 and tag[disp_addr]=disp_tag.
- Priority: a dispatch write beats a CDB clear on the same register in the same cycle; the entry stays busy with the new tag, and rf_write_en[i] still pulses for the old value. Two dispatch writes to the same register: the highest port index wins.
- R0_HARDWIRED=1: writes to register 0 are dropped; rd_busy for address 0 is always 0, rf_write_en[0] is always 0.
- Reads are combinational from stored state with CDB forwarding: if the addressed entry matches any CDB this cycle, rd_busy=0 and rd_tag=0.
- Reads do not see same-cycle dispatch writes. Intra-group dependencies are resolved by the dispatcher. A write becomes visible to reads on the next cycle.
- busy_count is a register updated every edge to the popcount of the next-state busy vector; range 0..NUM_REGS, no wrap.
- Duplicate CDB tags in one cycle are illegal; the bench asserts against them.

Optional Feature:
Macro RST_CHECKPOINT_EN.
- Defined: adds ports ckpt_save (in, 1) and ckpt_restore (in, 1), plus one shadow copy of busy/tag.
  - ckpt_save: the shadow captures the next-state array, including this cycle's writes and clears.
  - While held, the shadow also applies CDB clears every cycle.
  - ckpt_restore: the main array loads the shadow with CDB clears applied; this cycle's dispatch writes are discarded; busy_count is recomputed.
  - Simultaneous save and restore: restore wins and the shadow is unchanged.
- Undefined: no ports, no shadow storage.

Decomposition:
- Package rst_pkg: entry struct {busy, tag}, TAG_W/NUM_REGS defaults, and a popcount function.
- Sub-module rst_entry: one entry's next-state logic, handling dispatch priority, CDB match and the R0 drop. Instantiated NUM_REGS times via generate.

Test Plan:
1. Reset, then disp port0 reg5 tag 0x12 -> next cycle rd_addr0=5 gives rd_busy=1, rd_tag=0x12; busy_count=1.
2. Reg5 busy tag 0x12; cdb0 tag 0x12 -> same cycle rd_busy=0, rf_write_en[5]=1, rf_write_sel[5]=0; next cycle busy_count=0.
3. Reg7 busy tag 0x03; same cycle cdb1 tag 0x03 plus disp reg7 tag 0x09 -> rf_write_en[7]=1 (sel=1); next cycle busy with tag 0x09.
4. disp0 reg9 tag 0x01 and disp1 reg9 tag 0x02 together -> reg9 tag 0x02; busy_count increments by 1. Disp to reg0 -> ignored.
5. Regs 3 and 4 both busy with tag 0x00 (illegal pair excluded); single reg3 tag 0x00 with cdb0 tag 0x00 -> clears, confirming tag 0 is handled.
6. RST_CHECKPOINT_EN: save with reg2 busy tag 0x05; disp reg2 tag 0x06; cdb 0x05; restore -> reg2 not busy, busy_count=0.

Source files
------------

// File: rtl/reg_status_table_mp_pkg.sv
// Shared types and helpers for the multi-port register status table.
// Optional build macro: RST_CHECKPOINT_EN (adds the checkpoint shadow).
package rst_pkg;

    // Default geometry; the top-level parameters default to these.
    // The entry struct below is sized by RST_TAG_W.
    localparam int RST_NUM_REGS = 32;
    localparam int RST_TAG_W    = 6;
    localparam int RST_CNT_W    = $clog2(RST_NUM_REGS) + 1;

    // One status entry. The tag is meaningful only while busy is set.
    typedef struct packed {
        logic                 busy;
        logic [RST_TAG_W-1:0] tag;
    } rst_entry_t;

    function automatic logic [RST_CNT_W-1:0] popcount(
        input logic [RST_NUM_REGS-1:0] v
    );
        logic [RST_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < RST_NUM_REGS; i++) begin
            n = n + RST_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/reg_status_table_mp_if.sv
// Bundle of dispatch, CDB, read and RF-strobe signals of the status table.
// master: dispatcher/CDB side driving requests; slave: the table itself.
// Optional build macro: RST_CHECKPOINT_EN adds ckpt_save / ckpt_restore.
interface reg_status_table_mp_if
    import rst_pkg::*;
#(
    parameter int NUM_REGS = RST_NUM_REGS,
    parameter int TAG_W    = RST_TAG_W,
    parameter int NUM_RD   = 4,
    parameter int NUM_DISP = 2,
    parameter int NUM_CDB  = 2
);
    localparam int AW    = $clog2(NUM_REGS);
    localparam int SEL_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

    logic [NUM_DISP-1:0]          disp_we;
    logic [NUM_DISP*AW-1:0]       disp_addr;
    logic [NUM_DISP*TAG_W-1:0]    disp_tag;
    logic [NUM_CDB-1:0]           cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]     cdb_tag;
    logic [NUM_RD*AW-1:0]         rd_addr;
    logic [NUM_RD-1:0]            rd_busy;
    logic [NUM_RD*TAG_W-1:0]      rd_tag;
    logic [NUM_REGS-1:0]          rf_write_en;
    logic [NUM_REGS*SEL_W-1:0]    rf_write_sel;
    logic [AW:0]                  busy_count;
`ifdef RST_CHECKPOINT_EN
    logic                         ckpt_save;
    logic                         ckpt_restore;

    modport master (
        output disp_we, disp_addr, disp_tag,
        output cdb_valid, cdb_tag, rd_addr,
        output ckpt_save, ckpt_restore,
        input  rd_busy, rd_tag,
        input  rf_write_en, rf_write_sel, busy_count
    );

    modport slave (
        input  disp_we, disp_addr, disp_tag,
        input  cdb_valid, cdb_tag, rd_addr,
        input  ckpt_save, ckpt_restore,
        output rd_busy, rd_tag,
        output rf_write_en, rf_write_sel, busy_count
    );
`else
    modport master (
        output disp_we, disp_addr, disp_tag,
        output cdb_valid, cdb_tag, rd_addr,
        input  rd_busy, rd_tag,
        input  rf_write_en, rf_write_sel, busy_count
    );

    modport slave (
        input  disp_we, disp_addr, disp_tag,
        input  cdb_valid, cdb_tag, rd_addr,
        output rd_busy, rd_tag,
        output rf_write_en, rf_write_sel, busy_count
    );
`endif

endinterface

// File: rtl/reg_status_table_mp_entry.sv
// Next-state logic of one status entry: CDB match, dispatch priority, R0 drop.
// Ports: cur/nxt entry, dispatch + CDB buses, wr_en/wr_sel RF strobe;
// with RST_CHECKPOINT_EN also sh_cur -> sh_clr (shadow with CDB clears).
module rst_entry
    import rst_pkg::*;
#(
    parameter int IDX          = 0,
    parameter int AW           = 5,
    parameter int TAG_W        = RST_TAG_W,
    parameter int NUM_DISP     = 2,
    parameter int NUM_CDB      = 2,
    parameter int SEL_W        = 1,
    parameter int R0_HARDWIRED = 1
) (
`ifdef RST_CHECKPOINT_EN
    input  rst_entry_t                sh_cur,
    output rst_entry_t                sh_clr,
`endif
    input  rst_entry_t                cur,
    input  logic [NUM_DISP-1:0]       disp_we,
    input  logic [NUM_DISP*AW-1:0]    disp_addr,
    input  logic [NUM_DISP*TAG_W-1:0] disp_tag,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    output rst_entry_t                nxt,
    output logic                      wr_en,
    output logic [SEL_W-1:0]          wr_sel
);
    localparam logic [AW-1:0] MY_ADDR = AW'(IDX);
    localparam bit IS_R0 = (R0_HARDWIRED != 0) && (IDX == 0);

    logic             hit;
    logic [SEL_W-1:0] sel;

    // Descending scan so the lowest matching CDB index is the one kept.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cur.tag == cdb_tag[k*TAG_W +: TAG_W]) begin
                hit = 1'b1;
                sel = SEL_W'(k);
            end
        end
    end

    always_comb begin
        wr_en  = cur.busy && hit;
        wr_sel = wr_en ? sel : '0;
        nxt    = cur;
        if (wr_en) begin
            nxt.busy = 1'b0;
        end
        // Later ports overwrite earlier ones: highest index wins, and any
        // dispatch beats the CDB clear while wr_en still pulses.
        for (int p = 0; p < NUM_DISP; p++) begin
            if (disp_we[p] && disp_addr[p*AW +: AW] == MY_ADDR) begin
                nxt.busy = 1'b1;
                nxt.tag  = disp_tag[p*TAG_W +: TAG_W];
            end
        end
        if (IS_R0) begin
            nxt    = '0;
            wr_en  = 1'b0;
            wr_sel = '0;
        end
    end

`ifdef RST_CHECKPOINT_EN
    logic sh_hit;

    always_comb begin
        sh_hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid[k] && sh_cur.tag == cdb_tag[k*TAG_W +: TAG_W]) begin
                sh_hit = 1'b1;
            end
        end
        sh_clr = sh_cur;
        if (sh_cur.busy && sh_hit) begin
            sh_clr.busy = 1'b0;
        end
        if (IS_R0) begin
            sh_clr = '0;
        end
    end
`endif

endmodule

// File: rtl/reg_status_table_mp.sv
// Multi-port register status table: busy/tag per register, CDB forwarding.
// Ports: clk, reset (async active-low), bus (reg_status_table_mp_if.slave).
// Optional build macro: RST_CHECKPOINT_EN adds one checkpoint shadow copy.
module reg_status_table_mp
    import rst_pkg::*;
#(
    parameter int NUM_REGS     = RST_NUM_REGS,
    parameter int TAG_W        = RST_TAG_W,
    parameter int NUM_RD       = 4,
    parameter int NUM_DISP     = 2,
    parameter int NUM_CDB      = 2,
    parameter int R0_HARDWIRED = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_status_table_mp_if.slave bus
);
    localparam int AW    = $clog2(NUM_REGS);
    localparam int SEL_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

    rst_entry_t st_q    [NUM_REGS];
    rst_entry_t st_d    [NUM_REGS];
    rst_entry_t ent_nxt [NUM_REGS];

    logic [NUM_REGS-1:0]       wen;
    logic [NUM_REGS*SEL_W-1:0] wsel;
    logic [NUM_REGS-1:0]       busy_d;
    logic [AW:0]               cnt_q;

`ifdef RST_CHECKPOINT_EN
    rst_entry_t sh_q   [NUM_REGS];
    rst_entry_t sh_d   [NUM_REGS];
    rst_entry_t sh_clr [NUM_REGS];
`endif

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_ent
        rst_entry #(
            .IDX          (i),
            .AW           (AW),
            .TAG_W        (TAG_W),
            .NUM_DISP     (NUM_DISP),
            .NUM_CDB      (NUM_CDB),
            .SEL_W        (SEL_W),
            .R0_HARDWIRED (R0_HARDWIRED)
        ) u_ent (
`ifdef RST_CHECKPOINT_EN
            .sh_cur    (sh_q[i]),
            .sh_clr    (sh_clr[i]),
`endif
            .cur       (st_q[i]),
            .disp_we   (bus.disp_we),
            .disp_addr (bus.disp_addr),
            .disp_tag  (bus.disp_tag),
            .cdb_valid (bus.cdb_valid),
            .cdb_tag   (bus.cdb_tag),
            .nxt       (ent_nxt[i]),
            .wr_en     (wen[i]),
            .wr_sel    (wsel[i*SEL_W +: SEL_W])
        );
    end

`ifdef RST_CHECKPOINT_EN
    // Restore discards this cycle's dispatches and leaves the shadow as is.
    // Otherwise the shadow either snapshots the next state or keeps
    // retiring CDB results so it is current when restored.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            st_d[i] = ent_nxt[i];
            sh_d[i] = sh_clr[i];
            if (bus.ckpt_restore) begin
                st_d[i] = sh_clr[i];
                sh_d[i] = sh_q[i];
            end else if (bus.ckpt_save) begin
                sh_d[i] = ent_nxt[i];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            st_d[i] = ent_nxt[i];
        end
    end
`endif

    always_comb begin
        busy_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_d[i] = st_d[i].busy;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                st_q[i] <= '0;
`ifdef RST_CHECKPOINT_EN
                sh_q[i] <= '0;
`endif
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                st_q[i] <= st_d[i];
`ifdef RST_CHECKPOINT_EN
                sh_q[i] <= sh_d[i];
`endif
            end
            cnt_q <= popcount(busy_d);
        end
    end

    // Reads see stored state only; an entry retiring on a CDB this cycle
    // is forwarded as ready.
    logic [NUM_RD-1:0]       rd_busy;
    logic [NUM_RD*TAG_W-1:0] rd_tag;
    logic [AW-1:0]           ra;

    always_comb begin
        rd_busy = '0;
        rd_tag  = '0;
        ra      = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            ra = bus.rd_addr[r*AW +: AW];
            if (st_q[ra].busy && !wen[ra]) begin
                rd_busy[r]                = 1'b1;
                rd_tag[r*TAG_W +: TAG_W]  = st_q[ra].tag;
            end
        end
    end

    assign bus.rd_busy      = rd_busy;
    assign bus.rd_tag       = rd_tag;
    assign bus.rf_write_en  = wen;
    assign bus.rf_write_sel = wsel;
    assign bus.busy_count   = cnt_q;

endmodule
